gru_seq_cell: RTL and testbench

- Sequential, parametrised successor to the single-step combinational GRU cell.
- Processes a stream of scalar fixed-point inputs x[t] and carries hidden state h across timesteps in an internal register.
- Uses one time-shared multiply-accumulate datapath driven by an FSM, with valid/ready handshakes on input and output.
- A sequence-end marker clears h so the next sequence starts from zero.
- Sits between the feature-sample source and the downstream classifier/logger.

---
 rtl/gru_pkg.sv | 71 +++++++
 rtl/gru_act.sv | 57 +++++
 rtl/gru_seq_cell.sv | 228 ++++++++++++++++++++++
 tb/tb_gru_seq_cell.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gru_pkg.sv
// ============================================================================
// Module : gru_pkg
// Shared FSM encoding, fixed-point constants and saturation helper for the
// sequential GRU cell.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gru_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_Z = 3'd1,
    CALC_R = 3'd2,
    CALC_H = 3'd3,
    UPDATE = 3'd4,
    OUT    = 3'd5
  } state_t;

  typedef enum logic {
    ACT_SIG  = 1'b0,
    ACT_TANH = 1'b1
  } act_mode_t;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int FRACT_WIDTH_DEF = 5;
  localparam int SAT_W           = 64;

  // Slots of the latched coefficient bank.
  localparam int C_WZ   = 0;
  localparam int C_WR   = 1;
  localparam int C_WH   = 2;
  localparam int C_UZ   = 3;
  localparam int C_UR   = 4;
  localparam int C_UH   = 5;
  localparam int C_BZ   = 6;
  localparam int C_BR   = 7;
  localparam int C_BH   = 8;
  localparam int N_COEF = 9;

  function automatic int unit_of(input int fw);
    return 1 << fw;
  endfunction

  function automatic int acc_w_of(input int dw);
    return 2 * dw + 2;
  endfunction

  localparam int ONE   = unit_of(FRACT_WIDTH_DEF);
  localparam int HALF  = ONE / 2;
  localparam int ACC_W = acc_w_of(DATA_WIDTH_DEF);

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] a,
                                                  input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = 64'sd1 <<< (w - 1);
    hi = hi - 64'sd1;
    lo = -hi - 64'sd1;
    if (a > hi) begin
      return hi;
    end else if (a < lo) begin
      return lo;
    end
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gru_act.sv
// ============================================================================
// Module : gru_act
// Combinational hard-sigmoid / hard-tanh on a Q-format word, chosen by mode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gru_act
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5
) (
  input  act_mode_t                     mode,
  input  logic signed [DATA_WIDTH-1:0]  a,
  output logic signed [DATA_WIDTH-1:0]  y
);

  localparam int XW = DATA_WIDTH + 1;
  localparam logic signed [XW-1:0] UNIT_X     = XW'(unit_of(FRACT_WIDTH));
  localparam logic signed [XW-1:0] NEG_UNIT_X = -UNIT_X;
  localparam logic signed [XW-1:0] HALF_X     = XW'(unit_of(FRACT_WIDTH) / 2);

  logic signed [XW-1:0] a_x;
  logic signed [XW-1:0] quarter;
  logic signed [XW-1:0] sig_pre;
  logic signed [XW-1:0] res_x;

  // One guard bit keeps the +HALF offset and the clamp compares overflow-free.
  always_comb begin
    a_x     = {a[DATA_WIDTH-1], a};
    quarter = a_x >>> 2;
    sig_pre = quarter + HALF_X;
    res_x   = '0;
    if (mode == ACT_SIG) begin
      if (sig_pre[XW-1]) begin
        res_x = '0;
      end else if (sig_pre > UNIT_X) begin
        res_x = UNIT_X;
      end else begin
        res_x = sig_pre;
      end
    end else begin
      if (a_x > UNIT_X) begin
        res_x = UNIT_X;
      end else if (a_x < NEG_UNIT_X) begin
        res_x = NEG_UNIT_X;
      end else begin
        res_x = a_x;
      end
    end
    y = res_x[DATA_WIDTH-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/gru_seq_cell.sv
// ============================================================================
// Module : gru_seq_cell
// Streaming scalar GRU cell: one shared dual-product MAC stepped by an FSM,
// hidden state carried across samples and cleared after a sequence end.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gru_seq_cell
  import gru_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FRACT_WIDTH = 5   // must not exceed DATA_WIDTH-2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DATA_WIDTH-1:0]  s_x,
  input  logic                   s_last,
  input  logic [DATA_WIDTH-1:0]  Wz,
  input  logic [DATA_WIDTH-1:0]  Wr,
  input  logic [DATA_WIDTH-1:0]  Wh,
  input  logic [DATA_WIDTH-1:0]  Uz,
  input  logic [DATA_WIDTH-1:0]  Ur,
  input  logic [DATA_WIDTH-1:0]  Uh,
  input  logic [DATA_WIDTH-1:0]  bz,
  input  logic [DATA_WIDTH-1:0]  br,
  input  logic [DATA_WIDTH-1:0]  bh,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_h,
  output logic                   m_last
);

  localparam int UNIT      = unit_of(FRACT_WIDTH);
  localparam int ACC_WIDTH = acc_w_of(DATA_WIDTH);
  localparam int PW        = 2 * DATA_WIDTH;
  localparam logic signed [DATA_WIDTH-1:0] UNIT_D = DATA_WIDTH'(UNIT);

  state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0]          x_q, x_d;
  logic                                  last_q, last_d;
  logic [N_COEF-1:0][DATA_WIDTH-1:0]     coef_q, coef_d;
  logic signed [DATA_WIDTH-1:0]          h_q, h_d;
  logic signed [DATA_WIDTH-1:0]          z_q, z_d;
  logic signed [DATA_WIDTH-1:0]          r_q, r_d;
  logic signed [DATA_WIDTH-1:0]          hc_q, hc_d;
  logic [DATA_WIDTH-1:0]                 m_h_q, m_h_d;
  logic                                  m_last_q, m_last_d;
  logic                                  m_valid_q, m_valid_d;

  // Shared MAC datapath
  logic signed [DATA_WIDTH-1:0]  mul_a0, mul_b0, mul_a1, mul_b1, bias;
  logic signed [PW-1:0]          prod0, prod1;
  logic signed [ACC_WIDTH-1:0]   acc, acc_shift, pre_sum;
  logic signed [DATA_WIDTH-1:0]  pre_sat;
  logic signed [DATA_WIDTH-1:0]  act_out;
  act_mode_t                     act_mode;

  // Reset-gate scaling of h feeding the candidate pre-activation
  logic signed [PW-1:0]          rh_prod, rh_shift;
  logic signed [DATA_WIDTH-1:0]  rh;

  always_comb begin
    mul_a0   = '0;
    mul_b0   = '0;
    mul_a1   = '0;
    mul_b1   = '0;
    bias     = '0;
    act_mode = ACT_SIG;
    case (state_q)
      CALC_Z: begin
        mul_a0 = coef_q[C_WZ];
        mul_b0 = x_q;
        mul_a1 = coef_q[C_UZ];
        mul_b1 = h_q;
        bias   = coef_q[C_BZ];
      end
      CALC_R: begin
        mul_a0 = coef_q[C_WR];
        mul_b0 = x_q;
        mul_a1 = coef_q[C_UR];
        mul_b1 = h_q;
        bias   = coef_q[C_BR];
      end
      CALC_H: begin
        mul_a0   = coef_q[C_WH];
        mul_b0   = x_q;
        mul_a1   = coef_q[C_UH];
        mul_b1   = rh;
        bias     = coef_q[C_BH];
        act_mode = ACT_TANH;
      end
      UPDATE: begin
        // z lies in [0, ONE], so ONE-z always fits the data width.
        mul_a0 = UNIT_D - z_q;
        mul_b0 = h_q;
        mul_a1 = z_q;
        mul_b1 = hc_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    prod0     = mul_a0 * mul_b0;
    prod1     = mul_a1 * mul_b1;
    acc       = ACC_WIDTH'(prod0) + ACC_WIDTH'(prod1);
    acc_shift = acc >>> FRACT_WIDTH;
    pre_sum   = acc_shift + ACC_WIDTH'(bias);
    pre_sat   = DATA_WIDTH'(sat(SAT_W'(pre_sum), DATA_WIDTH));

    rh_prod   = r_q * h_q;
    rh_shift  = rh_prod >>> FRACT_WIDTH;
    rh        = DATA_WIDTH'(sat(SAT_W'(rh_shift), DATA_WIDTH));
  end

  gru_act #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_act (
    .mode (act_mode),
    .a    (pre_sat),
    .y    (act_out)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    last_d    = last_q;
    coef_d    = coef_q;
    h_d       = h_q;
    z_d       = z_q;
    r_d       = r_q;
    hc_d      = hc_q;
    m_h_d     = m_h_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          x_d          = s_x;
          last_d       = s_last;
          coef_d[C_WZ] = Wz;
          coef_d[C_WR] = Wr;
          coef_d[C_WH] = Wh;
          coef_d[C_UZ] = Uz;
          coef_d[C_UR] = Ur;
          coef_d[C_UH] = Uh;
          coef_d[C_BZ] = bz;
          coef_d[C_BR] = br;
          coef_d[C_BH] = bh;
          state_d      = CALC_Z;
        end
      end
      CALC_Z: begin
        z_d     = act_out;
        state_d = CALC_R;
      end
      CALC_R: begin
        r_d     = act_out;
        state_d = CALC_H;
      end
      CALC_H: begin
        hc_d    = act_out;
        state_d = UPDATE;
      end
      UPDATE: begin
        h_d       = pre_sat;
        m_h_d     = pre_sat;
        m_last_d  = last_q;
        m_valid_d = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
          // A delivered sequence end starts the next sequence from h = 0.
          if (m_last_q) begin
            h_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      x_q       <= '0;
      last_q    <= 1'b0;
      coef_q    <= '0;
      h_q       <= '0;
      z_q       <= '0;
      r_q       <= '0;
      hc_q      <= '0;
      m_h_q     <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      last_q    <= last_d;
      coef_q    <= coef_d;
      h_q       <= h_d;
      z_q       <= z_d;
      r_q       <= r_d;
      hc_q      <= hc_d;
      m_h_q     <= m_h_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign m_valid = m_valid_q;
  assign m_h     = m_h_q;
  assign m_last  = m_last_q;

endmodule

`default_nettype wire

// File: tb/tb_gru_seq_cell.sv
// ============================================================================
// Module : tb_gru_seq_cell
// Directed and randomised self-checking bench for gru_seq_cell (Q3.5).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_gru_seq_cell;

  typedef struct {
    logic signed [7:0] wz, uz, bz, wr, ur, br, wh, uh, bh;
  } coef_t;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_x;
  logic       s_last;
  logic [7:0] Wz, Wr, Wh, Uz, Ur, Uh, bz, br, bh;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_h;
  logic       m_last;

  int checks = 0;
  int errors = 0;

  gru_seq_cell #(
    .DATA_WIDTH  (8),
    .FRACT_WIDTH (5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_x     (s_x),
    .s_last  (s_last),
    .Wz      (Wz),
    .Wr      (Wr),
    .Wh      (Wh),
    .Uz      (Uz),
    .Ur      (Ur),
    .Uh      (Uh),
    .bz      (bz),
    .br      (br),
    .bh      (bh),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_h     (m_h),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic coef_t mk(input int wz, input int uz, input int bz_i,
                               input int wr, input int ur, input int br_i,
                               input int wh, input int uh, input int bh_i);
    coef_t c;
    c.wz = 8'(wz);   c.uz = 8'(uz);   c.bz = 8'(bz_i);
    c.wr = 8'(wr);   c.ur = 8'(ur);   c.br = 8'(br_i);
    c.wh = 8'(wh);   c.uh = 8'(uh);   c.bh = 8'(bh_i);
    return c;
  endfunction

  task automatic drive_coef(input coef_t c);
    Wz = c.wz; Uz = c.uz; bz = c.bz;
    Wr = c.wr; Ur = c.ur; br = c.br;
    Wh = c.wh; Uh = c.uh; bh = c.bh;
  endtask

  // Garbage on every weight port after acceptance: results must only
  // depend on what was captured at the accept edge.
  task automatic scramble();
    Wz = 8'($urandom); Uz = 8'($urandom); bz = 8'($urandom);
    Wr = 8'($urandom); Ur = 8'($urandom); br = 8'($urandom);
    Wh = 8'($urandom); Uh = 8'($urandom); bh = 8'($urandom);
    s_x = 8'($urandom); s_last = 1'($urandom);
  endtask

  function automatic int clampi(input int a, input int lo, input int hi);
    if (a < lo) return lo;
    if (a > hi) return hi;
    return a;
  endfunction

  // Integer reference of one timestep in Q3.5 (ONE = 32).
  function automatic int model_step(input coef_t c, input int x, input int h);
    int pz, pr, rh, ph, z, r, hc;
    pz = clampi(((int'(c.wz) * x + int'(c.uz) * h) >>> 5) + int'(c.bz), -128, 127);
    z  = clampi((pz >>> 2) + 16, 0, 32);
    pr = clampi(((int'(c.wr) * x + int'(c.ur) * h) >>> 5) + int'(c.br), -128, 127);
    r  = clampi((pr >>> 2) + 16, 0, 32);
    rh = clampi((r * h) >>> 5, -128, 127);
    ph = clampi(((int'(c.wh) * x + int'(c.uh) * rh) >>> 5) + int'(c.bh), -128, 127);
    hc = clampi(ph, -32, 32);
    return clampi(((32 - z) * h + z * hc) >>> 5, -128, 127);
  endfunction

  // Present one sample and return at the falling edge after it is accepted.
  task automatic start(input logic [7:0] x, input logic last, input coef_t c);
    int n;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_x     = x;
    s_last  = last;
    drive_coef(c);
    @(negedge clk);
    s_valid = 1'b0;
    scramble();
  endtask

  // Wait for the result, check latency/data, and complete the handshake
  // when m_ready is already high.
  task automatic finish(input string tag, input logic [7:0] exp_h, input logic exp_last);
    int n;
    n = 0;
    while (!m_valid && n < 30) begin
      chk({tag, "/busy_s_ready"}, 32'(s_ready), 32'd0);
      scramble();
      @(negedge clk);
      n++;
    end
    chk({tag, "/latency"}, 32'(n), 32'd4);
    chk({tag, "/m_h"}, 32'(m_h), 32'(exp_h));
    chk({tag, "/m_last"}, 32'(m_last), 32'(exp_last));
    chk({tag, "/out_s_ready"}, 32'(s_ready), 32'd0);
    if (m_ready) begin
      @(negedge clk);
      chk({tag, "/post_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "/post_s_ready"}, 32'(s_ready), 32'd1);
    end
  endtask

  coef_t forced, hold, satp, satn, mixed, flr, rc;
  int          hm, e;
  logic [7:0]  ev;
  logic signed [7:0] xs;
  logic        lst;

  initial begin
    forced = mk(0, 0, 127,  0, 0, 0,   32, 0, 0);
    hold   = mk(0, 0, -128, 0, 0, 0,   0, 0, 0);
    satp   = mk(0, 0, 127,  0, 0, 0,   127, 0, 0);
    satn   = mk(0, 0, 127,  0, 0, 0,   -128, 0, 0);
    mixed  = mk(16, 32, 0,  0, 64, -8, 16, 32, 4);
    flr    = mk(0, 0, 0,    0, 0, 0,   32, -32, 0);

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_x     = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    drive_coef(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("rst/m_valid", 32'(m_valid), 32'd0);
    chk("rst/m_h", 32'(m_h), 32'd0);
    chk("rst/m_last", 32'(m_last), 32'd0);
    chk("rst/s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel/s_ready", 32'(s_ready), 32'd1);

    // z = 1.0, hc = Wh*x = 0.5 -> h = 0.5
    start(8'd16, 1'b0, forced);
    finish("forced", 8'd16, 1'b0);
    // z = 0 keeps h; the last flag then clears it
    start(8'd77, 1'b1, hold);
    finish("hold_last", 8'd16, 1'b1);
    start(8'd77, 1'b0, hold);
    finish("after_last", 8'd0, 1'b0);

    // 127*127 >>> 5 saturates to 127 -> hc clamps to +ONE, and mirrored
    start(8'd127, 1'b0, satp);
    finish("sat_pos", 8'd32, 1'b0);
    start(8'd127, 1'b0, satn);
    finish("sat_neg", 8'hE0, 1'b0);

    // Output held under backpressure; input pulses ignored
    m_ready = 1'b0;
    start(8'd16, 1'b0, forced);
    finish("bp", 8'd16, 1'b0);
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'($urandom);
      s_x     = 8'($urandom);
      @(negedge clk);
      chk("bp/m_valid", 32'(m_valid), 32'd1);
      chk("bp/m_h", 32'(m_h), 32'd16);
      chk("bp/m_last", 32'(m_last), 32'd0);
      chk("bp/s_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel/m_valid", 32'(m_valid), 32'd0);
    chk("bp_rel/s_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("bp_idle/m_valid", 32'(m_valid), 32'd0);
    end

    // h = 16: z = 24, r = 22, rh = 11, hc = 31 -> (8*16 + 24*31) >> 5 = 27
    start(8'd32, 1'b0, mixed);
    finish("mixed", 8'd27, 1'b0);
    // h = 27, x = -20: rh = 13, hc = -32, z = 16 -> floor(-80/32) = -3
    start(8'hEC, 1'b1, flr);
    finish("floor", 8'hFD, 1'b1);

    // Reset during CALC_H wipes the output and h
    start(8'd16, 1'b0, forced);
    finish("pre_rst", 8'd16, 1'b0);
    start(8'd5, 1'b0, hold);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst/m_valid", 32'(m_valid), 32'd0);
    chk("midrst/m_h", 32'(m_h), 32'd0);
    chk("midrst/m_last", 32'(m_last), 32'd0);
    chk("midrst/s_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst/no_out", 32'(m_valid), 32'd0);
    start(8'd5, 1'b0, hold);
    finish("midrst_h0", 8'd0, 1'b0);
    start(8'd16, 1'b0, forced);
    finish("midrst_forced", 8'd16, 1'b0);

    // Random stream against the integer reference
    hm = 16;
    for (int i = 0; i < 200; i++) begin
      rc.wz = 8'($urandom); rc.uz = 8'($urandom); rc.bz = 8'($urandom);
      rc.wr = 8'($urandom); rc.ur = 8'($urandom); rc.br = 8'($urandom);
      rc.wh = 8'($urandom); rc.uh = 8'($urandom); rc.bh = 8'($urandom);
      xs  = 8'($urandom);
      lst = ($urandom_range(0, 7) == 0);
      e   = model_step(rc, int'(xs), hm);
      ev  = e[7:0];
      start(xs, lst, rc);
      finish("rand", ev, lst);
      hm = lst ? 0 : e;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
